// File: rtl/data_mem_stage.sv
// ----------------------------------------------------------------------------
// data_mem_stage
//   MEM-stage access controller sitting between the EXMEM and MEMWB pipeline
//   registers. A single-cycle MemRead/MemWrite strobe from EXMEM is turned
//   into a req/ack transaction towards a variable-latency data memory. While
//   the access is in flight stall_o freezes PC, IFID, IDEX and EXMEM. Load
//   data is presented to MEMWB in the cycle the pipeline is released.
//
// Ports
//   clk_i          in   1       clock, rising edge
//   rst_i          in   1       asynchronous, active-low reset
//   MemRead_i      in   1       load request (EXMEM)
//   MemWrite_i     in   1       store request (EXMEM)
//   addr_i         in   ADDR_W  byte address (EXMEM ALU result)
//   wdata_i        in   DATA_W  store data (EXMEM)
//   mem_req_o      out  1       request to data memory (registered)
//   mem_we_o       out  1       1 = write, 0 = read; valid while mem_req_o = 1
//   mem_addr_o     out  ADDR_W  latched address
//   mem_wdata_o    out  DATA_W  latched store data
//   mem_ack_i      in   1       single-cycle completion from data memory
//   mem_rdata_i    in   DATA_W  read data; valid when mem_ack_i = 1
//   stall_o        out  1       pipeline freeze (combinational)
//   rdata_o        out  DATA_W  load result to MEMWB ReadData_i
//   rdata_valid_o  out  1       rdata_o holds a completed load (DONE only)
//   misalign_o     out  1       one-cycle pulse: misaligned access dropped
//   timeout_o      out  1       sticky: an access hit MAX_WAIT
//
// State table
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no access in flight; aligned MemRead/MemWrite is captured
//   BUSY   | mem_req_o asserted, waiting for mem_ack_i or MAX_WAIT expiry
//   DONE   | one release cycle; EXMEM still holds the finished op, so
//          | strobes are ignored here to avoid issuing it twice
// ----------------------------------------------------------------------------
module data_mem_stage #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rdata_valid_o,
   output logic              misalign_o,
   output logic              timeout_o
);

   localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t              state_q, state_d;

   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                we_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                rd_ok_q;
   logic                misalign_q;
   logic                timeout_q;

   logic                acc;
   logic                aligned;
   logic                start;
   logic                bad;
   logic                hit;
   logic                last;
   logic                expire;

   // ------------------------------------------------------------------------
   // Event decode shared by the FSM and the datapath
   // ------------------------------------------------------------------------
   assign acc     = MemRead_i | MemWrite_i;
   assign aligned = (addr_i[1:0] == 2'b00);
   assign last    = (cnt_q == CNT_W'(MAX_WAIT - 1));

   assign start   = (state_q == S_IDLE) &  acc &  aligned;
   assign bad     = (state_q == S_IDLE) &  acc & ~aligned;
   assign hit     = (state_q == S_BUSY) &  mem_ack_i;
   // An ack arriving in the final allowed BUSY cycle still counts as success.
   assign expire  = (state_q == S_BUSY) & ~mem_ack_i & last;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (hit || expire) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      stall_o       = 1'b0;
      rdata_valid_o = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            stall_o = start;
         end
         S_BUSY: begin
            mem_req_o = 1'b1;
            mem_we_o  = we_q;
            stall_o   = 1'b1;
         end
         S_DONE: begin
            rdata_valid_o = rd_ok_q;
         end
         default: begin
            stall_o = 1'b0;
         end
      endcase
      // stall_o is combinational from the EXMEM strobes; force it low while
      // reset is held so the pipeline is never frozen by a stale strobe.
      if (!rst_i) begin
         stall_o = 1'b0;
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign rdata_o     = rdata_q;
   assign misalign_o  = misalign_q;
   assign timeout_o   = timeout_q;

   // ------------------------------------------------------------------------
   // Datapath: request latch, wait counter, load result, status flags
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         rd_ok_q    <= 1'b0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         misalign_q <= bad;

         if (start) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            // A stray MemRead alongside MemWrite is treated as a store.
            we_q    <= MemWrite_i;
            cnt_q   <= '0;
            rd_ok_q <= 1'b0;
         end

         if ((state_q == S_BUSY) && !hit && !expire) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         if (hit) begin
            rd_ok_q <= ~we_q;
            if (!we_q) begin
               rdata_q <= mem_rdata_i;
            end
         end

         if (expire) begin
            rdata_q   <= '0;
            rd_ok_q   <= 1'b0;
            timeout_q <= 1'b1;
         end
      end
   end

endmodule
